// File: rtl/nmea_pkg.sv
// Shared definitions for the NMEA sentence front-end.
//   state_t    : capture sequencer states
//   DOLLAR/STAR: framing characters
//   hex2nib    : ASCII hex digit decode, returns {ok, nibble}
//   SENTENCE_W : width of the packed sentence word handed to the parser
package nmea_pkg;

    localparam int SENTENCE_W = 560;

    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] STAR   = 8'h2A;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BODY,
        CK_HI,
        CK_LO,
        CMP,
        HOLD
    } state_t;

    // Only uppercase hex is legal in an NMEA checksum; lowercase is rejected.
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        logic [7:0] d;
        logic [4:0] res;
        res = 5'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            d   = c - 8'h30;
            res = {1'b1, d[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            d   = c - 8'h37;
            res = {1'b1, d[3:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/nmea_timeout.sv
// Inter-byte gap timer.
//   sclk, rstn : clock, asynchronous active-low reset
//   run        : timer counts only while high; held loaded otherwise
//   reload     : byte arrived, restart the gap measurement
//   expire     : gap has reached CYCLES clock cycles (suppressed on reload)
module nmea_timeout #(
    parameter int CYCLES = 200_000
) (
    input  logic sclk,
    input  logic rstn,
    input  logic run,
    input  logic reload,
    output logic expire
);

    localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);
    // Loading CYCLES-1 makes expire visible in the cycle after CYCLES-1
    // decrements, so the error registers exactly CYCLES cycles after the byte.
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= LOAD;
        end else if (!run || reload) begin
            count_reg <= LOAD;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // A byte in the expiry cycle wins: reload masks the expiry.
    assign expire = run && !reload && (count_reg == '0);

endmodule

// File: rtl/nmea_sentence_ctrl.sv
// NMEA GGA sentence framer: captures '$'..checksum, checks header and XOR
// checksum, presents the packed sentence with valid/ready, keeps counters.
//   sclk, rstn        : clock, asynchronous active-low reset
//   rx_data, rx_valid : byte stream from the UART receiver
//   sentence_data/len : packed sentence (byte 0 in MSBs) and its byte count
//   sentence_valid/ready : handshake towards the parser
//   good_cnt/err_cnt/drop_cnt : saturating telemetry counters
//   busy              : sequencer not idle
module nmea_sentence_ctrl
    import nmea_pkg::*;
#(
    parameter int          SYSCLK_FREQ = 100_000_000,
    parameter int          TIMEOUT_US  = 2000,
    parameter int          MAX_BYTES   = 70,
    parameter logic [39:0] HEADER      = "GPGGA"
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [SENTENCE_W-1:0] sentence_data,
    output logic [6:0]            sentence_len,
    output logic                  sentence_valid,
    input  logic                  sentence_ready,
    output logic [15:0]           good_cnt,
    output logic [15:0]           err_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  busy
);

    localparam int         TIMEOUT_CYCLES = SYSCLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam logic [6:0] MAX_LEN        = 7'(MAX_BYTES);

    state_t     state_reg, state_next;
    logic [6:0] len_reg, len_next;
    logic [7:0] csum_reg, csum_next;
    logic [7:0] ck_reg, ck_next;
    logic       valid_reg, valid_next;
    logic [15:0] good_reg, err_reg, drop_reg;
    logic       good_inc, err_inc, drop_inc;
    logic       buf_clr, buf_wr;
    logic       capturing, to_expire;
    logic [7:0] hdr_char;
    logic [4:0] hex_res;

    assign capturing = (state_reg == HDR) || (state_reg == BODY) ||
                       (state_reg == CK_HI) || (state_reg == CK_LO);
    assign hex_res   = hex2nib(rx_data);

    // Expected header character for the byte about to be stored at len_reg.
    always_comb begin
        hdr_char = HEADER[7:0];
        case (len_reg)
            7'd1:    hdr_char = HEADER[39:32];
            7'd2:    hdr_char = HEADER[31:24];
            7'd3:    hdr_char = HEADER[23:16];
            7'd4:    hdr_char = HEADER[15:8];
            default: hdr_char = HEADER[7:0];
        endcase
    end

    nmea_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .sclk   (sclk),
        .rstn   (rstn),
        .run    (capturing),
        .reload (rx_valid),
        .expire (to_expire)
    );

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        csum_next  = csum_reg;
        ck_next    = ck_reg;
        valid_next = valid_reg;
        good_inc   = 1'b0;
        err_inc    = 1'b0;
        drop_inc   = 1'b0;
        buf_clr    = 1'b0;
        buf_wr     = 1'b0;

        if (state_reg == IDLE) begin
            if (rx_valid && rx_data == DOLLAR) begin
                buf_clr    = 1'b1;
                len_next   = 7'd1;
                csum_next  = 8'h00;
                state_next = HDR;
            end
        end else if (capturing) begin
            if (rx_valid) begin
                if (rx_data == DOLLAR) begin
                    // Resync: abandon the partial sentence, restart on this '$'.
                    err_inc    = 1'b1;
                    buf_clr    = 1'b1;
                    len_next   = 7'd1;
                    csum_next  = 8'h00;
                    state_next = HDR;
                end else if (len_reg >= MAX_LEN) begin
                    err_inc    = 1'b1;
                    state_next = IDLE;
                end else if (state_reg == HDR) begin
                    if (rx_data == hdr_char) begin
                        buf_wr    = 1'b1;
                        csum_next = csum_reg ^ rx_data;
                        len_next  = len_reg + 7'd1;
                        if (len_reg == 7'd5) begin
                            state_next = BODY;
                        end
                    end else begin
                        err_inc    = 1'b1;
                        state_next = IDLE;
                    end
                end else if (state_reg == BODY) begin
                    buf_wr   = 1'b1;
                    len_next = len_reg + 7'd1;
                    if (rx_data == STAR) begin
                        state_next = CK_HI;
                    end else begin
                        csum_next = csum_reg ^ rx_data;
                    end
                end else if (hex_res[4]) begin
                    buf_wr   = 1'b1;
                    len_next = len_reg + 7'd1;
                    if (state_reg == CK_HI) begin
                        ck_next    = {hex_res[3:0], ck_reg[3:0]};
                        state_next = CK_LO;
                    end else begin
                        ck_next    = {ck_reg[7:4], hex_res[3:0]};
                        state_next = CMP;
                    end
                end else begin
                    err_inc    = 1'b1;
                    state_next = IDLE;
                end
            end else if (to_expire) begin
                err_inc    = 1'b1;
                state_next = IDLE;
            end
        end else if (state_reg == CMP) begin
            // A byte landing in this single compare cycle is ignored.
            if (ck_reg == csum_reg) begin
                valid_next = 1'b1;
                state_next = HOLD;
            end else begin
                err_inc    = 1'b1;
                state_next = IDLE;
            end
        end else begin
            // HOLD: buffer is frozen until the parser takes it.
            if (rx_valid) begin
                drop_inc = 1'b1;
            end
            if (sentence_ready) begin
                good_inc   = 1'b1;
                valid_next = 1'b0;
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            len_reg   <= 7'd0;
            csum_reg  <= 8'h00;
            ck_reg    <= 8'h00;
            valid_reg <= 1'b0;
            good_reg  <= 16'h0000;
            err_reg   <= 16'h0000;
            drop_reg  <= 16'h0000;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            csum_reg  <= csum_next;
            ck_reg    <= ck_next;
            valid_reg <= valid_next;
            if (good_inc && good_reg != 16'hFFFF) good_reg <= good_reg + 16'd1;
            if (err_inc  && err_reg  != 16'hFFFF) err_reg  <= err_reg  + 16'd1;
            if (drop_inc && drop_reg != 16'hFFFF) drop_reg <= drop_reg + 16'd1;
        end
    end

    // Sentence buffer: one register per byte so the whole sentence is
    // presented in parallel. Clearing on '$' leaves unused bytes at 0x00.
    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_buf
            logic [7:0] byte_reg;
            always_ff @(posedge sclk or negedge rstn) begin
                if (!rstn) begin
                    byte_reg <= 8'h00;
                end else if (buf_clr) begin
                    byte_reg <= (gi == 0) ? DOLLAR : 8'h00;
                end else if (buf_wr && len_reg == 7'(gi)) begin
                    byte_reg <= rx_data;
                end
            end
            assign sentence_data[SENTENCE_W-1-8*gi -: 8] = byte_reg;
        end
    endgenerate

    assign sentence_len   = len_reg;
    assign sentence_valid = valid_reg;
    assign good_cnt       = good_reg;
    assign err_cnt        = err_reg;
    assign drop_cnt       = drop_reg;
    assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_nmea_sentence_ctrl.sv
module tb_nmea_sentence_ctrl;
    import nmea_pkg::*;

    logic                  sclk = 1'b0;
    logic                  rstn = 1'b0;
    logic [7:0]            rx_data = 8'h00;
    logic                  rx_valid = 1'b0;
    logic [SENTENCE_W-1:0] sentence_data;
    logic [6:0]            sentence_len;
    logic                  sentence_valid;
    logic                  sentence_ready = 1'b1;
    logic [15:0]           good_cnt, err_cnt, drop_cnt;
    logic                  busy;

    // 1 us timeout at 100 MHz gives a 100-cycle gap limit.
    nmea_sentence_ctrl #(
        .SYSCLK_FREQ (100_000_000),
        .TIMEOUT_US  (1),
        .MAX_BYTES   (70),
        .HEADER      ("GPGGA")
    ) dut (
        .sclk           (sclk),
        .rstn           (rstn),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .sentence_data  (sentence_data),
        .sentence_len   (sentence_len),
        .sentence_valid (sentence_valid),
        .sentence_ready (sentence_ready),
        .good_cnt       (good_cnt),
        .err_cnt        (err_cnt),
        .drop_cnt       (drop_cnt),
        .busy           (busy)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [SENTENCE_W-1:0] data;
        logic [6:0]            len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_good = 0;
    int   exp_err = 0;
    int   exp_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    function automatic logic [SENTENCE_W-1:0] pack_str(input string s);
        logic [SENTENCE_W-1:0] d;
        d = '0;
        for (int i = 0; i < s.len(); i++) begin
            d[SENTENCE_W-1-8*i -: 8] = s[i];
        end
        return d;
    endfunction

    task automatic expect_sentence(input string s);
        exp_t e;
        e.data = pack_str(s);
        e.len  = 7'(s.len());
        exp_q.push_back(e);
    endtask

    // Returns 1 ns after the edge that sampled the byte.
    task automatic send_byte(input logic [7:0] b);
        @(posedge sclk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge sclk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
    endtask

    // One byte every 16 cycles.
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            idle(14);
        end
    endtask

    task automatic send_crlf();
        send_byte(8'h0D);
        idle(14);
        send_byte(8'h0A);
        idle(14);
    endtask

    task automatic check_counters(input string tag);
        #1;
        check({tag, ".good_cnt"}, 64'(good_cnt), 64'(exp_good));
        check({tag, ".err_cnt"},  64'(err_cnt),  64'(exp_err));
        check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
        check({tag, ".busy"},     64'(busy),     64'd0);
    endtask

    // Scoreboard monitor: every completed handshake must match the oldest
    // expected sentence.
    always @(negedge sclk) begin
        if (rstn && sentence_valid && sentence_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb.unexpected actual_len=%0d required=no sentence", sentence_len);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (sentence_data !== e.data || sentence_len !== e.len) begin
                    errors++;
                    $display("FAIL sb.sentence actual len=%0d data=%h required len=%0d data=%h",
                             sentence_len, sentence_data, e.len, e.data);
                end else begin
                    $display("ok   sb.sentence len=%0d", sentence_len);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SENTENCE_W-1:0] snap;

        // Reset state
        idle(3);
        #1;
        check("rst.valid", 64'(sentence_valid), 64'd0);
        check("rst.len",   64'(sentence_len),   64'd0);
        check("rst.data_zero", 64'(sentence_data != '0), 64'd0);
        check_counters("rst");
        rstn = 1'b1;
        idle(3);

        // Good sentence with trailing CR/LF
        expect_sentence("$GPGGA,1*4B");
        send_str("$GPGGA,1*4B");
        send_crlf();
        exp_good++;
        check_counters("good");

        // Bad checksum
        send_str("$GPGGA,1*4C");
        idle(5);
        exp_err++;
        check_counters("badck");

        // Wrong header, then lowercase hex digit
        send_str("$GPRMC,1*4B");
        exp_err++;
        send_str("$GPGGA,1*4g");
        exp_err++;
        idle(5);
        check_counters("hdr_hex");

        // Resync on '$' in BODY
        expect_sentence("$GPGGA,1*4B");
        send_str("$GPGGA,12$GPGGA,1*4B");
        exp_err++;
        exp_good++;
        idle(5);
        check_counters("resync");

        // Overflow: byte 71 is rejected
        send_str("$GPGGA");
        for (int i = 0; i < 64; i++) send_str(",");
        #1;
        check("ovf.err_before", 64'(err_cnt), 64'(exp_err));
        check("ovf.busy_at_70", 64'(busy), 64'd1);
        check("ovf.len_at_70",  64'(sentence_len), 64'd70);
        send_byte(8'h2C);
        exp_err++;
        check("ovf.err_byte71", 64'(err_cnt), 64'(exp_err));
        idle(14);
        for (int i = 0; i < 15; i++) send_str(",");
        check_counters("ovf");

        // Backpressure: latency, stability and dropped bytes while holding
        sentence_ready = 1'b0;
        expect_sentence("$GPGGA,1*4B");
        send_str("$GPGGA,1*4");
        send_byte("B");
        check("bp.valid_cmp_cycle", 64'(sentence_valid), 64'd0);
        @(posedge sclk);
        #1;
        check("bp.valid_latency2", 64'(sentence_valid), 64'd1);
        snap = sentence_data;
        send_byte(8'h0D);
        idle(14);
        send_byte(8'h0A);
        idle(14);
        send_byte(8'h24);
        idle(53);
        exp_drop += 3;
        #1;
        check("bp.data_stable", 64'(sentence_data == snap), 64'd1);
        check("bp.len", 64'(sentence_len), 64'd11);
        check("bp.valid_held", 64'(sentence_valid), 64'd1);
        check("bp.drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        check("bp.good_before", 64'(good_cnt), 64'(exp_good));
        @(posedge sclk);
        #1;
        sentence_ready = 1'b1;
        @(posedge sclk);
        #1;
        exp_good++;
        check("bp.valid_after_hs", 64'(sentence_valid), 64'd0);
        check_counters("bp");

        // Timeout: error registers exactly 100 cycles after the last byte
        send_str("$GP");
        send_byte("G");
        repeat (99) @(posedge sclk);
        #1;
        check("to.err_at_99", 64'(err_cnt), 64'(exp_err));
        check("to.busy_at_99", 64'(busy), 64'd1);
        @(posedge sclk);
        #1;
        exp_err++;
        check("to.err_at_100", 64'(err_cnt), 64'(exp_err));
        check_counters("to");

        // Asynchronous reset mid-BODY
        send_str("$GPGGA,1");
        @(posedge sclk);
        #3;
        rstn = 1'b0;
        #1;
        exp_good = 0;
        exp_err = 0;
        exp_drop = 0;
        check("arst.len", 64'(sentence_len), 64'd0);
        check("arst.data_zero", 64'(sentence_data != '0), 64'd0);
        check("arst.valid", 64'(sentence_valid), 64'd0);
        check_counters("arst");
        @(posedge sclk);
        #1;
        rstn = 1'b1;
        expect_sentence("$GPGGA,1*4B");
        send_str("$GPGGA,1*4B");
        send_crlf();
        exp_good++;
        check_counters("post_rst");

        check("sb.pending", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
